// File: rtl/ldpc_r2c_pkg.sv
// Shared types and default sizes for the LDPC row-to-column transpose buffer.
package ldpc_r2c_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_ROWS = 6;
  localparam int DEF_N_COLS = 7;

  typedef logic [DEF_DATA_W-1:0] llr_t;
  typedef logic                  bank_idx_t;
  typedef enum logic {R_IDLE = 1'b0, R_DRAIN = 1'b1} rd_state_e;
endpackage

// File: rtl/ldpc_r2c_bank.sv
// One transpose bank: N_ROWS x N_COLS LLR registers, row-wide write, column-wide read.
module ldpc_r2c_bank #(
  parameter int DATA_W = 8,
  parameter int N_ROWS = 6,
  parameter int N_COLS = 7,
  parameter int RW     = 3,
  parameter int CW     = 3
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [RW-1:0]            wr_row,
  input  logic [N_COLS*DATA_W-1:0] wr_data,
  input  logic [CW-1:0]            rd_col,
  output logic [N_ROWS*DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [N_ROWS][N_COLS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int c = 0; c < N_COLS; c++) begin
        mem[wr_row][c] <= wr_data[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      rd_data[r*DATA_W +: DATA_W] = mem[r][rd_col];
    end
  end
endmodule

// File: rtl/ldpc_row_col_transpose.sv
// Ping-pong transpose buffer: rows in, columns out, one bank fills while the other drains.
// Optional frame marking (i_last / o_last / o_frame_err) enabled by LDPC_R2C_LAST_EN.
module ldpc_row_col_transpose
  import ldpc_r2c_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_ROWS = DEF_N_ROWS,
  parameter int N_COLS = DEF_N_COLS
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [N_COLS*DATA_W-1:0] i_data,
  input  logic                     i_valid,
`ifdef LDPC_R2C_LAST_EN
  input  logic                     i_last,
  output logic                     o_last,
  output logic                     o_frame_err,
`endif
  output logic                     o_ready,
  output logic [N_ROWS*DATA_W-1:0] o_data,
  output logic                     o_valid,
  input  logic                     i_ready
);
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(N_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);

  bank_idx_t                wr_bank, rd_bank;
  logic [RW-1:0]            wr_row;
  logic [CW-1:0]            rd_col;
  logic [1:0]               bank_full, bank_full_nxt;
  rd_state_e                rd_state, rd_state_nxt;
  logic                     wr_fire, wr_last, rd_fire, rd_last;
  logic [N_ROWS*DATA_W-1:0] bank_rd [2];

  // o_ready is forced low while reset is held, independent of the flags
  assign o_ready = i_reset && !bank_full[wr_bank];
  assign wr_fire = i_valid && o_ready;
  assign wr_last = (wr_row == ROW_LAST);
  assign rd_fire = o_valid && i_ready;
  assign rd_last = (rd_col == COL_LAST);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ldpc_r2c_bank #(
      .DATA_W(DATA_W), .N_ROWS(N_ROWS), .N_COLS(N_COLS), .RW(RW), .CW(CW)
    ) u_bank (
      .clk     (i_clock),
      .we      (wr_fire && (wr_bank == bank_idx_t'(b))),
      .wr_row  (wr_row),
      .wr_data (i_data),
      .rd_col  (rd_col),
      .rd_data (bank_rd[b])
    );
  end

  // Completing one bank and releasing the other on the same edge both land
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_fire && wr_last) bank_full_nxt[wr_bank] = 1'b1;
    if (rd_fire && rd_last) bank_full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      wr_bank   <= 1'b0;
      wr_row    <= '0;
      rd_bank   <= 1'b0;
      rd_col    <= '0;
      bank_full <= '0;
    end else begin
      bank_full <= bank_full_nxt;
      if (wr_fire) begin
        wr_row <= wr_last ? '0 : wr_row + 1'b1;
        if (wr_last) wr_bank <= ~wr_bank;
      end
      if (rd_fire) begin
        rd_col <= rd_last ? '0 : rd_col + 1'b1;
        if (rd_last) rd_bank <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) rd_state <= R_IDLE;
    else          rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:  if (bank_full[rd_bank]) rd_state_nxt = R_DRAIN;
      R_DRAIN: if (rd_fire && rd_last) rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    o_valid = bank_full[rd_bank];
    o_data  = o_valid ? bank_rd[rd_bank] : '0;
  end

`ifdef LDPC_R2C_LAST_EN
  logic frame_err;

  always_ff @(posedge i_clock) begin
    if (!i_reset)                           frame_err <= 1'b0;
    else if (wr_fire && (i_last != wr_last)) frame_err <= 1'b1;
  end

  assign o_frame_err = frame_err;
  assign o_last      = o_valid && rd_last;
`endif
endmodule

// File: tb/tb_ldpc_row_col_transpose.sv
// Bench for ldpc_row_col_transpose: table-driven single block, directed corner sequences,
// and randomized handshakes against a queue-based transpose model.
module tb_ldpc_row_col_transpose;
  import ldpc_r2c_pkg::*;

  localparam int DATA_W = 8;
  localparam int N_ROWS = 6;
  localparam int N_COLS = 7;
  localparam int IW = N_COLS * DATA_W;
  localparam int OW = N_ROWS * DATA_W;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic [IW-1:0] i_data  = '0;
  logic          o_ready, o_valid;
  logic [OW-1:0] o_data;
`ifdef LDPC_R2C_LAST_EN
  logic i_last = 1'b0;
  logic o_last, o_frame_err;
  logic exp_err = 1'b0;
  int   last_row = N_ROWS - 1;
`endif

  int tests = 0;
  int fails = 0;
  int drained = 0;
  logic [IW-1:0] cur_rows[$];
  logic [OW-1:0] exp_cols[$];
  logic          smp_valid, smp_ready;
  logic [OW-1:0] smp_data;

  always #5 i_clock = ~i_clock;

  ldpc_row_col_transpose #(.DATA_W(DATA_W), .N_ROWS(N_ROWS), .N_COLS(N_COLS)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_data  (i_data),
    .i_valid (i_valid),
`ifdef LDPC_R2C_LAST_EN
    .i_last      (i_last),
    .o_last      (o_last),
    .o_frame_err (o_frame_err),
`endif
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] row_word(input int r, input logic [7:0] hi);
    logic [IW-1:0] w;
    logic [3:0] rr, cc;
    w = '0;
    rr = 4'(r);
    for (int c = 0; c < N_COLS; c++) begin
      cc = 4'(c);
      w[c*DATA_W +: DATA_W] = hi | {rr, cc};
    end
    return w;
  endfunction

  function automatic logic [OW-1:0] col_word(input int c, input logic [7:0] hi);
    logic [OW-1:0] w;
    logic [3:0] rr, cc;
    w = '0;
    cc = 4'(c);
    for (int r = 0; r < N_ROWS; r++) begin
      rr = 4'(r);
      w[r*DATA_W +: DATA_W] = hi | {rr, cc};
    end
    return w;
  endfunction

  // One clock: drive, check against the model at negedge, advance the model after posedge.
  task automatic cycle(input logic rst_n, input logic v, input logic [IW-1:0] d,
                       input logic r, output logic acc);
    int full;
    logic ev, er;
    logic [IW-1:0] row;
    logic [OW-1:0] col;
    llr_t lane;
    i_reset = rst_n; i_valid = v; i_data = d; i_ready = r;
`ifdef LDPC_R2C_LAST_EN
    i_last = (cur_rows.size() == last_row);
`endif
    full = (exp_cols.size() + N_COLS - 1) / N_COLS;
    ev = (full > 0);
    er = rst_n && (full < 2);
    @(negedge i_clock);
    smp_valid = o_valid; smp_ready = o_ready; smp_data = o_data;
    chk("o_ready", 64'(o_ready), 64'(er));
    chk("o_valid", 64'(o_valid), 64'(ev));
    if (ev) chk("o_data", 64'(o_data), 64'(exp_cols[0]));
    else    chk("o_data_idle", 64'(o_data), 64'(0));
`ifdef LDPC_R2C_LAST_EN
    chk("o_last", 64'(o_last), 64'(ev && (exp_cols.size() % N_COLS == 1)));
    chk("o_frame_err", 64'(o_frame_err), 64'(exp_err));
`endif
    acc = v && er;
    @(posedge i_clock);
    #1;
    if (!rst_n) begin
      cur_rows.delete();
      exp_cols.delete();
`ifdef LDPC_R2C_LAST_EN
      exp_err = 1'b0;
`endif
    end else begin
      if (ev && r) begin
        void'(exp_cols.pop_front());
        drained++;
      end
      if (acc) begin
`ifdef LDPC_R2C_LAST_EN
        if (i_last != (cur_rows.size() == N_ROWS - 1)) exp_err = 1'b1;
`endif
        cur_rows.push_back(d);
        if (cur_rows.size() == N_ROWS) begin
          for (int c = 0; c < N_COLS; c++) begin
            col = '0;
            for (int rr = 0; rr < N_ROWS; rr++) begin
              row = cur_rows[rr];
              lane = row[c*DATA_W +: DATA_W];
              col[rr*DATA_W +: DATA_W] = lane;
            end
            exp_cols.push_back(col);
          end
          cur_rows.delete();
        end
      end
    end
  endtask

  typedef struct {
    logic          v;
    logic [IW-1:0] d;
    logic          exp_valid;
    logic [OW-1:0] exp_data;
  } vec_t;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    logic acc;
    int n, d0, gaps;
    logic started;

    for (int r = 0; r < N_ROWS; r++) tbl[r] = '{1'b1, row_word(r, 8'h00), 1'b0, '0};
    for (int c = 0; c < N_COLS; c++) tbl[N_ROWS + c] = '{1'b0, '0, 1'b1, col_word(c, 8'h00)};
    tbl[13] = '{1'b0, '0, 1'b0, '0};

    // reset state
    i_reset = 1'b0;
    repeat (2) @(posedge i_clock);
    #1;
    cycle(1'b0, 1'b1, '1, 1'b1, acc);
    chk("reset_o_ready", 64'(smp_ready), 64'(0));

    // 1: single block, table driven
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, tbl[i].v, tbl[i].d, 1'b1, acc);
      chk($sformatf("tbl%0d_valid", i), 64'(smp_valid), 64'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_data", i), 64'(smp_data), 64'(tbl[i].exp_data));
    end

    // 2: back-to-back blocks, alternate blocks carry 8'h80
    n = 0; d0 = drained; gaps = 0; started = 1'b0;
    for (int k = 0; k < 80 && n < 4 * N_ROWS; k++) begin
      cycle(1'b1, 1'b1, row_word(n % N_ROWS, ((n / N_ROWS) % 2) ? 8'h80 : 8'h00), 1'b1, acc);
      if (smp_valid) started = 1'b1;
      else if (started) gaps++;
      if (acc) n++;
    end
    for (int k = 0; k < 60 && exp_cols.size() > 0; k++) begin
      cycle(1'b1, 1'b0, '0, 1'b1, acc);
      if (!smp_valid && exp_cols.size() > 0) gaps++;
    end
    chk("b2b_accepted", 64'(n), 64'(4 * N_ROWS));
    chk("b2b_gaps", 64'(gaps), 64'(0));
    chk("b2b_drained", 64'(drained - d0), 64'(4 * N_COLS));

    // 3: downstream stalled, three blocks offered
    n = 0; d0 = drained;
    for (int k = 0; k < 30; k++) begin
      cycle(1'b1, 1'b1, row_word(n % N_ROWS, (n >= N_ROWS) ? 8'h80 : 8'h00), 1'b0, acc);
      if (acc) n++;
    end
    chk("stall_accepted", 64'(n), 64'(2 * N_ROWS));
    chk("stall_o_ready", 64'(smp_ready), 64'(0));
    for (int k = 0; k < 40 && exp_cols.size() > 0; k++) cycle(1'b1, 1'b0, '0, 1'b1, acc);
    chk("stall_drained", 64'(drained - d0), 64'(2 * N_COLS));

    // 4: reset after 3 rows while the other bank is full
    n = 0;
    for (int k = 0; k < 20 && n < N_ROWS + 3; k++) begin
      cycle(1'b1, 1'b1, row_word(n % N_ROWS, 8'h00), 1'b0, acc);
      if (acc) n++;
    end
    chk("pre_reset_rows", 64'(n), 64'(N_ROWS + 3));
    cycle(1'b0, 1'b0, '0, 1'b0, acc);
    cycle(1'b1, 1'b0, '0, 1'b1, acc);
    chk("post_reset_valid", 64'(smp_valid), 64'(0));
    chk("post_reset_data", 64'(smp_data), 64'(0));
    n = 0; d0 = drained;
    for (int k = 0; k < 40 && (n < N_ROWS || exp_cols.size() > 0); k++) begin
      cycle(1'b1, n < N_ROWS, row_word(n % N_ROWS, 8'h80), 1'b1, acc);
      if (acc) n++;
    end
    chk("post_reset_drained", 64'(drained - d0), 64'(N_COLS));

    // 5: random handshakes, 20 blocks
    n = 0; d0 = drained;
    for (int k = 0; k < 3000 && (drained - d0) < 20 * N_COLS; k++) begin
      cycle(1'b1, ($urandom % 2 == 1) && (n < 20 * N_ROWS),
            row_word(n % N_ROWS, ((n / N_ROWS) % 2) ? 8'h80 : 8'h00),
            ($urandom % 2 == 1), acc);
      if (acc) n++;
    end
    chk("rand_drained", 64'(drained - d0), 64'(20 * N_COLS));

`ifdef LDPC_R2C_LAST_EN
    // 6: misplaced i_last marks the frame error, which then sticks
    last_row = 4;
    n = 0;
    for (int k = 0; k < 40 && (n < N_ROWS || exp_cols.size() > 0); k++) begin
      cycle(1'b1, n < N_ROWS, row_word(n % N_ROWS, 8'h00), 1'b1, acc);
      if (acc) n++;
    end
    last_row = N_ROWS - 1;
    n = 0;
    for (int k = 0; k < 40 && (n < N_ROWS || exp_cols.size() > 0); k++) begin
      cycle(1'b1, n < N_ROWS, row_word(n % N_ROWS, 8'h80), 1'b1, acc);
      if (acc) n++;
    end
    chk("frame_err_sticky", 64'(o_frame_err), 64'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
